instruction_fetch: RTL and testbench

//  Fetch stage of the 16-bit CPU. Holds the PC, issues reads to instruction memory, captures the returned word and presents it to decode.

---
 rtl/instruction_fetch.sv | 79 +++++++
 tb/tb_instruction_fetch.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: multicycle fetch stage with a single outstanding memory read, branch redirect and decode back-pressure
module instruction_fetch #(
    parameter int PC_WIDTH = 16,
    parameter int INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int PC_STEP = 2
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Stall,
    input  logic                   BranchTaken,
    input  logic [PC_WIDTH-1:0]    BranchTarget,
    output logic                   IMemReq,
    output logic [PC_WIDTH-1:0]    IMemAddr,
    input  logic [INSTR_WIDTH-1:0] IMemData,
    input  logic                   IMemValid,
    output logic [INSTR_WIDTH-1:0] Instruction,
    output logic [2:0]             OPCODE,
    output logic                   InstrValid,
    output logic [PC_WIDTH-1:0]    PCPlus2
);
    localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_inc;
    logic                discard;

    assign pc_inc   = pc + STEP;
    assign IMemReq  = !Reset && state == S_FETCH && !BranchTaken;
    assign IMemAddr = pc;
    assign OPCODE   = Instruction[INSTR_WIDTH-1 -: 3];

    // fetch FSM: request, wait for data (dropping squashed words), hold until decode accepts
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            Instruction <= '0;
            InstrValid  <= 1'b0;
            PCPlus2     <= '0;
            discard     <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (BranchTaken) pc <= BranchTarget;
                    else state <= S_WAIT;
                end
                S_WAIT: begin
                    if (BranchTaken) pc <= BranchTarget;
                    if (IMemValid) begin
                        discard <= 1'b0;
                        if (!discard && !BranchTaken) begin
                            Instruction <= IMemData;
                            PCPlus2     <= pc_inc;
                            pc          <= pc_inc;
                            InstrValid  <= 1'b1;
                            state       <= S_HOLD;
                        end else begin
                            state <= S_FETCH;
                        end
                    end else if (BranchTaken) begin
                        discard <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (BranchTaken || !Stall) begin
                        InstrValid <= 1'b0;
                        state      <= S_FETCH;
                        if (BranchTaken) pc <= BranchTarget;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed and random checks of the fetch stage against a transaction-level model
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Stall = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [15:0] BranchTarget = '0;
    logic        IMemReq;
    logic [15:0] IMemAddr;
    logic [15:0] IMemData = '0;
    logic        IMemValid = 1'b0;
    logic [15:0] Instruction;
    logic [2:0]  OPCODE;
    logic        InstrValid;
    logic [15:0] PCPlus2;

    instruction_fetch dut (
        .Clock(clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
        .IMemData(IMemData), .IMemValid(IMemValid), .Instruction(Instruction),
        .OPCODE(OPCODE), .InstrValid(InstrValid), .PCPlus2(PCPlus2)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int lat = 1;

    // memory environment: one pending read with a chosen latency
    logic        mem_pending = 1'b0;
    logic [15:0] mem_addr = '0;
    int          mem_due = 0;
    logic        prev_rst = 1'b1;

    // model: fetch address, whether a read is in flight, whether it is doomed, and the word held for decode
    logic [15:0] m_pc = '0;
    logic        m_out = 1'b0;
    logic        m_drop = 1'b0;
    logic        m_valid = 1'b0;
    logic [15:0] m_instr = '0;
    logic [15:0] m_pc2 = '0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] h;
        h = (a * 16'h9E37) ^ 16'h3C5A;
        return a == 16'h0000 ? 16'hE123 : h;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic st, input logic br, input logic [15:0] tgt);
        logic exp_req;
        logic [15:0] nxt;
        @(negedge clk);
        Reset = r;
        Stall = st;
        BranchTaken = br;
        BranchTarget = tgt;
        IMemValid = 1'b0;
        IMemData = 16'($urandom);
        if (r) begin
            mem_pending = 1'b0;
            m_pc = '0; m_out = 1'b0; m_drop = 1'b0; m_valid = 1'b0; m_instr = '0; m_pc2 = '0;
        end else if (mem_pending && cyc >= mem_due) begin
            IMemValid = 1'b1;
            IMemData = mem_word(mem_addr);
            mem_pending = 1'b0;
        end else if (prev_rst || (!m_out && $urandom_range(0, 7) == 0)) begin
            IMemValid = 1'b1;
        end
        #1;
        exp_req = !r && !m_valid && !m_out && !br;
        chk("IMemReq", 32'(IMemReq), 32'(exp_req));
        chk("IMemAddr", 32'(IMemAddr), 32'(m_pc));
        chk("Instruction", 32'(Instruction), 32'(m_instr));
        chk("OPCODE", 32'(OPCODE), 32'(m_instr[15:13]));
        chk("InstrValid", 32'(InstrValid), 32'(m_valid));
        chk("PCPlus2", 32'(PCPlus2), 32'(m_pc2));
        if (!r && IMemReq) begin
            mem_pending = 1'b1;
            mem_addr = IMemAddr;
            mem_due = cyc + lat;
        end
        if (!r) begin
            nxt = m_pc + 16'd2;
            if (m_valid) begin
                if (br || !st) m_valid = 1'b0;
            end else if (m_out) begin
                if (IMemValid) begin
                    m_out = 1'b0;
                    if (!br && !m_drop) begin
                        m_valid = 1'b1;
                        m_instr = IMemData;
                        m_pc2 = nxt;
                        m_pc = nxt;
                    end
                    m_drop = 1'b0;
                end else if (br) begin
                    m_drop = 1'b1;
                end
            end else if (!br) begin
                m_out = 1'b1;
            end
            if (br) m_pc = tgt;
        end
        prev_rst = r;
        cyc++;
    endtask

    initial begin
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        // first fetch from reset address with single-cycle memory
        lat = 1;
        step(0, 0, 0, 0);
        chk("t1_req", 32'(IMemReq), 32'd1);
        chk("t1_addr", 32'(IMemAddr), 32'h0000);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("t1_valid", 32'(InstrValid), 32'd1);
        chk("t1_instr", 32'(Instruction), 32'hE123);
        chk("t1_opcode", 32'(OPCODE), 32'd7);
        chk("t1_pcplus2", 32'(PCPlus2), 32'h0002);
        step(0, 0, 0, 0);
        chk("t1_next_addr", 32'(IMemAddr), 32'h0002);
        // decode stall holds the word
        step(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0);
            chk("t2_instr", 32'(Instruction), 32'(mem_word(16'h0002)));
            chk("t2_pcplus2", 32'(PCPlus2), 32'h0004);
            chk("t2_req", 32'(IMemReq), 32'd0);
        end
        step(0, 0, 0, 0);
        // redirect during a slow read
        lat = 4;
        step(0, 0, 0, 0);
        chk("t2_next_addr", 32'(IMemAddr), 32'h0004);
        step(0, 0, 1, 16'h0040);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            chk("t3_valid", 32'(InstrValid), 32'd0);
        end
        lat = 1;
        step(0, 0, 0, 0);
        chk("t3_req", 32'(IMemReq), 32'd1);
        chk("t3_addr", 32'(IMemAddr), 32'h0040);
        // redirect squashes a stalled held word
        step(0, 0, 0, 0);
        step(0, 1, 1, 16'h0080);
        chk("t4_held", 32'(InstrValid), 32'd1);
        step(0, 1, 0, 0);
        chk("t4_valid", 32'(InstrValid), 32'd0);
        chk("t4_req", 32'(IMemReq), 32'd1);
        chk("t4_addr", 32'(IMemAddr), 32'h0080);
        // PC wrap at the top of the address space
        step(0, 0, 0, 0);
        step(0, 0, 1, 16'hFFFE);
        step(0, 0, 0, 0);
        chk("t5_addr", 32'(IMemAddr), 32'hFFFE);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("t5_pcplus2", 32'(PCPlus2), 32'h0000);
        step(0, 0, 0, 0);
        chk("t5_next_addr", 32'(IMemAddr), 32'h0000);
        // reset during a pending read, stale response afterwards
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        lat = 3;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("t6_rst_req", 32'(IMemReq), 32'd0);
        step(0, 0, 0, 0);
        chk("t6_stale_in", 32'(IMemValid), 32'd1);
        chk("t6_req", 32'(IMemReq), 32'd1);
        chk("t6_addr", 32'(IMemAddr), 32'h0000);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("t6_instr", 32'(Instruction), 32'hE123);
        chk("t6_valid", 32'(InstrValid), 32'd1);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            lat = $urandom_range(1, 5);
            step($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 11) == 0, 16'($urandom));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
